// File: rtl/uart_rx_core_if.sv
// Receive-side handshake bundle of the UART receiver.
// The receiver drives the master side; the register/FIFO consumer drives the slave side.
interface uart_rx_core_if #(
    parameter int DATA_BITS = 8
);
    logic                 rx_ready;
    logic [DATA_BITS-1:0] rx_data;
    logic                 rx_valid;
    logic                 frame_err;
    logic                 overrun_err;
    logic                 busy;

    modport master (
        input  rx_ready,
        output rx_data,
        output rx_valid,
        output frame_err,
        output overrun_err,
        output busy
    );

    modport slave (
        output rx_ready,
        input  rx_data,
        input  rx_valid,
        input  frame_err,
        input  overrun_err,
        input  busy
    );
endinterface

// File: rtl/uart_rx_core.sv
// 8N1 UART receiver: 16x oversampling, 2-of-3 majority bit decision, and a
// valid/ready holding register with framing and overrun error pulses.
module uart_rx_core #(
    parameter int CLK_DIV   = 27,
    parameter int DATA_BITS = 8
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            rx,
    input  logic            scan_in0,
    input  logic            scan_enable,
    input  logic            test_mode,
    output logic            scan_out0,
    uart_rx_core_if.master  bus
);

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        START = 3'd1,
        DATA  = 3'd2,
        STOP  = 3'd3,
        BREAK = 3'd4
    } state_e;

    localparam logic [15:0] DIV_LAST = 16'(CLK_DIV - 1);
    localparam logic [2:0]  BIT_LAST = 3'(DATA_BITS - 1);

    function automatic logic majority3(input logic a, input logic b, input logic c);
        return (a & b) | (a & c) | (b & c);
    endfunction

    state_e               state_q, state_d;
    logic                 rx_meta_q, rx_meta_d;
    logic                 rx_sync_q, rx_sync_d;
    logic [15:0]          div_cnt_q, div_cnt_d;
    logic [3:0]           s_cnt_q, s_cnt_d;
    logic [2:0]           bit_cnt_q, bit_cnt_d;
    logic [1:0]           samp_q, samp_d;
    logic [DATA_BITS-1:0] shift_q, shift_d;
    logic [DATA_BITS-1:0] rx_data_q, rx_data_d;
    logic                 rx_valid_q, rx_valid_d;
    logic                 frame_err_q, frame_err_d;
    logic                 overrun_err_q, overrun_err_d;
    logic                 busy_q, busy_d;

    logic rx_s;
    logic tick_s;
    logic decide_s;
    logic end_bit_s;
    logic bit_s;
    logic deliver_s;
    logic ferr_s;
    logic unused_scan_s;

    assign rx_s          = rx_sync_q;
    assign scan_out0     = 1'b0;
    assign unused_scan_s = ^{scan_in0, scan_enable, test_mode};

    // Oversample timing strobes and the majority-voted bit value
    always_comb begin
        tick_s    = (state_q != IDLE) && (div_cnt_q == DIV_LAST);
        decide_s  = tick_s && (s_cnt_q == 4'd8);
        end_bit_s = tick_s && (s_cnt_q == 4'd15);
        bit_s     = majority3(samp_q[0], samp_q[1], rx_s);
    end

    // Synchronizer, tick divider, sample index and frame FSM next state
    always_comb begin
        rx_meta_d = rx;
        rx_sync_d = rx_meta_q;
        state_d   = state_q;
        div_cnt_d = div_cnt_q;
        s_cnt_d   = s_cnt_q;
        bit_cnt_d = bit_cnt_q;
        samp_d    = samp_q;
        shift_d   = shift_q;
        deliver_s = 1'b0;
        ferr_s    = 1'b0;

        if (state_q == IDLE) begin
            div_cnt_d = 16'd0;
        end else if (tick_s) begin
            div_cnt_d = 16'd0;
        end else begin
            div_cnt_d = div_cnt_q + 16'd1;
        end

        // The s=8 sample is taken directly from rx_s in the decision cycle
        if (tick_s) begin
            s_cnt_d = s_cnt_q + 4'd1;
            if (s_cnt_q == 4'd6) begin
                samp_d[0] = rx_s;
            end else if (s_cnt_q == 4'd7) begin
                samp_d[1] = rx_s;
            end else begin
                samp_d = samp_q;
            end
        end else begin
            s_cnt_d = s_cnt_q;
        end

        case (state_q)
            IDLE: begin
                if (!rx_s) begin
                    state_d = START;
                    s_cnt_d = 4'd0;
                end else begin
                    state_d = IDLE;
                end
            end
            START: begin
                if (decide_s && bit_s) begin
                    state_d = IDLE;
                end else if (end_bit_s) begin
                    state_d   = DATA;
                    bit_cnt_d = 3'd0;
                end else begin
                    state_d = START;
                end
            end
            DATA: begin
                if (decide_s) begin
                    shift_d = {bit_s, shift_q[DATA_BITS-1:1]};
                end else begin
                    shift_d = shift_q;
                end
                if (end_bit_s) begin
                    if (bit_cnt_q == BIT_LAST) begin
                        state_d   = STOP;
                        bit_cnt_d = 3'd0;
                    end else begin
                        bit_cnt_d = bit_cnt_q + 3'd1;
                    end
                end else begin
                    state_d = DATA;
                end
            end
            STOP: begin
                if (decide_s) begin
                    if (bit_s) begin
                        deliver_s = 1'b1;
                        state_d   = IDLE;
                    end else begin
                        ferr_s  = 1'b1;
                        state_d = BREAK;
                    end
                end else begin
                    state_d = STOP;
                end
            end
            BREAK: begin
                if (rx_s) begin
                    state_d = IDLE;
                end else begin
                    state_d = BREAK;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Holding register, handshake and error pulses
    always_comb begin
        rx_data_d     = rx_data_q;
        rx_valid_d    = rx_valid_q;
        frame_err_d   = ferr_s;
        overrun_err_d = 1'b0;
        busy_d        = (state_d != IDLE);

        // A full register being drained this cycle can take the new byte at once
        if (deliver_s) begin
            if (!rx_valid_q || bus.rx_ready) begin
                rx_data_d  = shift_q;
                rx_valid_d = 1'b1;
            end else begin
                overrun_err_d = 1'b1;
            end
        end else if (rx_valid_q && bus.rx_ready) begin
            rx_valid_d = 1'b0;
        end else begin
            rx_valid_d = rx_valid_q;
        end
    end

    // State register with synchronous reset
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q       <= IDLE;
            rx_meta_q     <= 1'b1;
            rx_sync_q     <= 1'b1;
            div_cnt_q     <= 16'd0;
            s_cnt_q       <= 4'd0;
            bit_cnt_q     <= 3'd0;
            samp_q        <= 2'd0;
            shift_q       <= '0;
            rx_data_q     <= '0;
            rx_valid_q    <= 1'b0;
            frame_err_q   <= 1'b0;
            overrun_err_q <= 1'b0;
            busy_q        <= 1'b0;
        end else begin
            state_q       <= state_d;
            rx_meta_q     <= rx_meta_d;
            rx_sync_q     <= rx_sync_d;
            div_cnt_q     <= div_cnt_d;
            s_cnt_q       <= s_cnt_d;
            bit_cnt_q     <= bit_cnt_d;
            samp_q        <= samp_d;
            shift_q       <= shift_d;
            rx_data_q     <= rx_data_d;
            rx_valid_q    <= rx_valid_d;
            frame_err_q   <= frame_err_d;
            overrun_err_q <= overrun_err_d;
            busy_q        <= busy_d;
        end
    end

    assign bus.rx_data     = rx_data_q;
    assign bus.rx_valid    = rx_valid_q;
    assign bus.frame_err   = frame_err_q;
    assign bus.overrun_err = overrun_err_q;
    assign bus.busy        = busy_q;

endmodule

// File: tb/tb_uart_rx_core.sv
// Self-checking bench for uart_rx_core: serial frames are generated at 64 clk
// per bit, expected bytes go to a scoreboard queue and are popped on each transfer.
module tb_uart_rx_core;

    localparam int CLK_DIV = 4;
    localparam int BIT_T   = 16 * CLK_DIV;

    logic clk         = 1'b0;
    logic reset       = 1'b1;
    logic rx          = 1'b1;
    logic scan_in0    = 1'b0;
    logic scan_enable = 1'b0;
    logic test_mode   = 1'b0;
    logic scan_out0;

    uart_rx_core_if #(.DATA_BITS(8)) bus ();

    uart_rx_core #(.CLK_DIV(CLK_DIV), .DATA_BITS(8)) dut (
        .clk         (clk),
        .reset       (reset),
        .rx          (rx),
        .scan_in0    (scan_in0),
        .scan_enable (scan_enable),
        .test_mode   (test_mode),
        .scan_out0   (scan_out0),
        .bus         (bus)
    );

    always #5 clk = ~clk;

    int         errors = 0;
    int         checks = 0;
    int         cyc = 0;
    int         fe_cnt = 0;
    int         ov_cnt = 0;
    int         rise_cyc = -1;
    int         frame_start_cyc = 0;
    logic       prev_valid = 1'b0;
    logic [7:0] exp_q[$];

    always @(posedge clk) cyc <= cyc + 1;

    // Output monitor: counts error pulses and scores every completed transfer
    initial begin
        logic [7:0] exp;
        forever begin
            @(negedge clk);
            if (reset) begin
                prev_valid = 1'b0;
            end else begin
                if (bus.rx_valid && !prev_valid) rise_cyc = cyc;
                prev_valid = bus.rx_valid;
                if (bus.frame_err)   fe_cnt++;
                if (bus.overrun_err) ov_cnt++;
                if (bus.frame_err || bus.overrun_err) begin
                    checks++;
                    if (bus.frame_err && bus.overrun_err) begin
                        errors++;
                        $display("FAIL err_exclusive: frame_err=1 overrun_err=1, required at most one high");
                    end
                end
                if (bus.rx_valid && bus.rx_ready) begin
                    checks++;
                    if (exp_q.size() == 0) begin
                        errors++;
                        $display("FAIL unexpected_byte: rx_data=%h delivered, required no delivery", bus.rx_data);
                    end else begin
                        exp = exp_q.pop_front();
                        if (bus.rx_data !== exp) begin
                            errors++;
                            $display("FAIL rx_data: got %h, required %h", bus.rx_data, exp);
                        end
                    end
                end
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL timeout: simulation did not finish, errors=%0d", errors);
        $fatal(1, "timeout");
    end

    // Drives nbits of a frame (start, data LSB first, stop); cycles g_lo..g_hi are inverted
    task automatic send_frame(input logic [7:0] data, input logic stop_bit,
                              input int g_lo, input int g_hi, input int nbits);
        logic [9:0] bits;
        logic       v;
        bits = {stop_bit, data, 1'b0};
        for (int c = 0; c < nbits * BIT_T; c++) begin
            v = bits[c / BIT_T];
            if (c >= g_lo && c <= g_hi) v = ~v;
            @(posedge clk);
            #1;
            if (c == 0) frame_start_cyc = cyc;
            rx = v;
        end
    endtask

    task automatic drive_line(input logic v, input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
            rx = v;
        end
    endtask

    task automatic test_reset;
        reset = 1'b1;
        bus.rx_ready = 1'b1;
        repeat (4) @(posedge clk);
        @(negedge clk);
        checks++;
        if ({bus.rx_valid, bus.frame_err, bus.overrun_err, bus.busy, scan_out0, bus.rx_data} !== 13'd0) begin
            errors++;
            $display("FAIL reset_values: valid=%b ferr=%b ovr=%b busy=%b scan=%b data=%h, required all 0",
                     bus.rx_valid, bus.frame_err, bus.overrun_err, bus.busy, scan_out0, bus.rx_data);
        end
        @(posedge clk);
        #1;
        reset = 1'b0;
        drive_line(1'b1, 8);
    endtask

    task automatic test_basic;
        int fe0, ov0, lat;
        fe0 = fe_cnt;
        ov0 = ov_cnt;
        rise_cyc = -1;
        exp_q.push_back(8'hA5);
        send_frame(8'hA5, 1'b1, -1, -1, 10);
        drive_line(1'b1, 16);
        for (int i = 0; i < 50 && exp_q.size() != 0; i++) @(negedge clk);
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL basic_drain: %0d bytes pending, required 0", exp_q.size());
        end
        lat = rise_cyc - frame_start_cyc;
        checks++;
        if (rise_cyc < 0 || lat < 605 || lat > 625) begin
            errors++;
            $display("FAIL basic_latency: rx_valid rose %0d cycles after start edge, required 605..625", lat);
        end
        checks++;
        if (fe_cnt != fe0 || ov_cnt != ov0) begin
            errors++;
            $display("FAIL basic_flags: ferr pulses=%0d ovr pulses=%0d, required 0 and 0", fe_cnt - fe0, ov_cnt - ov0);
        end
        @(negedge clk);
        checks++;
        if (bus.busy !== 1'b0) begin
            errors++;
            $display("FAIL basic_busy_idle: busy=%b, required 0", bus.busy);
        end
    endtask

    task automatic test_false_start;
        drive_line(1'b0, 20);
        @(negedge clk);
        checks++;
        if (bus.busy !== 1'b1) begin
            errors++;
            $display("FAIL glitch_busy_high: busy=%b, required 1", bus.busy);
        end
        drive_line(1'b1, 60);
        @(negedge clk);
        checks++;
        if (bus.busy !== 1'b0 || bus.rx_valid !== 1'b0) begin
            errors++;
            $display("FAIL glitch_reject: busy=%b valid=%b, required 0 and 0", bus.busy, bus.rx_valid);
        end
        exp_q.push_back(8'h3C);
        send_frame(8'h3C, 1'b1, -1, -1, 10);
        drive_line(1'b1, 16);
        for (int i = 0; i < 50 && exp_q.size() != 0; i++) @(negedge clk);
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL glitch_drain: %0d bytes pending, required 0", exp_q.size());
        end
    endtask

    task automatic test_framing;
        int fe0;
        fe0 = fe_cnt;
        send_frame(8'h3C, 1'b0, -1, -1, 10);
        drive_line(1'b0, 3 * BIT_T);
        drive_line(1'b1, 32);
        @(negedge clk);
        checks++;
        if (fe_cnt != fe0 + 1) begin
            errors++;
            $display("FAIL frame_err_count: %0d pulses, required 1", fe_cnt - fe0);
        end
        checks++;
        if (bus.rx_valid !== 1'b0) begin
            errors++;
            $display("FAIL frame_discard: rx_valid=%b, required 0", bus.rx_valid);
        end
        exp_q.push_back(8'h55);
        send_frame(8'h55, 1'b1, -1, -1, 10);
        drive_line(1'b1, 16);
        for (int i = 0; i < 50 && exp_q.size() != 0; i++) @(negedge clk);
        checks++;
        if (exp_q.size() != 0 || fe_cnt != fe0 + 1) begin
            errors++;
            $display("FAIL frame_recover: pending=%0d ferr pulses=%0d, required 0 and 1", exp_q.size(), fe_cnt - fe0);
        end
    endtask

    task automatic test_overrun;
        int ov0;
        ov0 = ov_cnt;
        @(posedge clk);
        #1;
        bus.rx_ready = 1'b0;
        exp_q.push_back(8'h11);
        send_frame(8'h11, 1'b1, -1, -1, 10);
        send_frame(8'h22, 1'b1, -1, -1, 10);
        drive_line(1'b1, 16);
        @(negedge clk);
        checks++;
        if (ov_cnt != ov0 + 1) begin
            errors++;
            $display("FAIL overrun_count: %0d pulses, required 1", ov_cnt - ov0);
        end
        checks++;
        if (bus.rx_valid !== 1'b1) begin
            errors++;
            $display("FAIL overrun_hold_valid: rx_valid=%b, required 1", bus.rx_valid);
        end
        checks++;
        if (bus.rx_data !== 8'h11) begin
            errors++;
            $display("FAIL overrun_hold_data: rx_data=%h, required 11", bus.rx_data);
        end
        @(posedge clk);
        #1;
        bus.rx_ready = 1'b1;
        for (int i = 0; i < 10 && exp_q.size() != 0; i++) @(negedge clk);
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL overrun_drain: %0d bytes pending, required 0", exp_q.size());
        end
        @(negedge clk);
        checks++;
        if (bus.rx_valid !== 1'b0) begin
            errors++;
            $display("FAIL overrun_valid_clear: rx_valid=%b, required 0", bus.rx_valid);
        end
    endtask

    task automatic test_reset_midframe;
        int fe0;
        send_frame(8'h5A, 1'b1, -1, -1, 5);
        @(posedge clk);
        #1;
        reset = 1'b1;
        rx = 1'b1;
        @(posedge clk);
        #1;
        reset = 1'b0;
        fe0 = fe_cnt;
        @(negedge clk);
        checks++;
        if ({bus.rx_valid, bus.frame_err, bus.overrun_err, bus.busy, bus.rx_data} !== 12'd0) begin
            errors++;
            $display("FAIL midreset_values: valid=%b ferr=%b ovr=%b busy=%b data=%h, required all 0",
                     bus.rx_valid, bus.frame_err, bus.overrun_err, bus.busy, bus.rx_data);
        end
        drive_line(1'b1, 100);
        checks++;
        if (fe_cnt != fe0 || bus.busy !== 1'b0) begin
            errors++;
            $display("FAIL midreset_quiet: ferr pulses=%0d busy=%b, required 0 and 0", fe_cnt - fe0, bus.busy);
        end
        exp_q.push_back(8'hC3);
        send_frame(8'hC3, 1'b1, -1, -1, 10);
        drive_line(1'b1, 16);
        for (int i = 0; i < 50 && exp_q.size() != 0; i++) @(negedge clk);
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL midreset_drain: %0d bytes pending, required 0", exp_q.size());
        end
    endtask

    // Data bit 2 samples land 221, 225 and 229 cycles after the start edge
    task automatic test_majority;
        exp_q.push_back(8'hFF);
        send_frame(8'hFF, 1'b1, 223, 226, 10);
        drive_line(1'b1, 16);
        exp_q.push_back(8'hFB);
        send_frame(8'hFF, 1'b1, 219, 225, 10);
        drive_line(1'b1, 16);
        for (int i = 0; i < 50 && exp_q.size() != 0; i++) @(negedge clk);
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL majority_drain: %0d bytes pending, required 0", exp_q.size());
        end
    endtask

    initial begin
        bus.rx_ready = 1'b1;
        test_reset();
        test_basic();
        test_false_start();
        test_framing();
        test_overrun();
        test_reset_midframe();
        test_majority();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
